// File: rtl/pipe_mips32.sv
// pipe_mips32: five-stage (IF, ID, EX, MEM, WB) pipelined MIPS-like core with
// a unified 1024 x 32 word-addressed memory and a 32 x 32 register file.
//
// Ports:
//   clk1   - single system clock, all state updates on its rising edge
//   rst_n  - asynchronous active-low reset; clears PC, flags and valid bits,
//            leaves REG and MEM untouched so preloaded contents survive
//   halted - mirrors HALTED, set once a HLT instruction reaches WB
//
// Internals left at module scope for preload and inspection:
//   REG, MEM, PC, HALTED, TAKEN_BRANCH
//
// Pipeline register semantics: every stage register carries a valid bit.
// The payload beside it is meaningful only while that bit is 1; a 0 is a
// bubble that performs no register, memory or PC side effect. A stage either
// advances (takes the older stage's payload), holds (load-use stall on
// IF/ID), or is overwritten with a bubble (flush, stall, halt drain).
module pipe_mips32 (
  input  logic clk1,
  input  logic rst_n,
  output logic halted
);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  logic [31:0] REG [0:31];
  logic [31:0] MEM [0:1023];
  logic [9:0]  PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  // Stage registers
  logic        if_id_v;
  logic [31:0] if_id_ir;
  logic [9:0]  if_id_npc;

  logic        id_ex_v;
  logic [31:0] id_ex_ir, id_ex_a, id_ex_b;
  logic [9:0]  id_ex_npc;
  logic [4:0]  id_ex_dest;
  logic        id_ex_wen;

  logic        ex_mem_v;
  logic [31:0] ex_mem_alu, ex_mem_b;
  logic [4:0]  ex_mem_dest;
  logic        ex_mem_wen, ex_mem_lw, ex_mem_sw, ex_mem_hlt;

  logic        mem_wb_v;
  logic [31:0] mem_wb_val;
  logic [4:0]  mem_wb_dest;
  logic        mem_wb_wen, mem_wb_hlt;

  assign halted = HALTED;

  function automatic logic is_rr(input logic [5:0] op);
    return (op <= OP_MUL);
  endfunction

  function automatic logic is_ri(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_SLTI);
  endfunction

  function automatic logic uses_rs(input logic [5:0] op);
    return is_rr(op) || is_ri(op) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BNEQZ) || (op == OP_BEQZ);
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return is_rr(op) || (op == OP_SW);
  endfunction

  // ---------------- WB (write-through into the ID read) ----------------
  logic wb_we;
  assign wb_we = mem_wb_v && mem_wb_wen && !HALTED;

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0)                         return 32'd0;
    else if (wb_we && (mem_wb_dest == idx))  return mem_wb_val;
    else                                     return REG[idx];
  endfunction

  // ---------------- ID ----------------
  logic [5:0]  op_d;
  logic [4:0]  rs_d, rt_d, dest_d;
  logic        wen_d;
  logic [31:0] rda_d, rdb_d;

  assign op_d   = if_id_ir[31:26];
  assign rs_d   = if_id_ir[25:21];
  assign rt_d   = if_id_ir[20:16];
  assign dest_d = is_rr(op_d) ? if_id_ir[15:11] : rt_d;
  // Destination R0 is treated as "no write", which also keeps R0 out of
  // every forwarding and stall comparison.
  assign wen_d  = (is_rr(op_d) || is_ri(op_d) || (op_d == OP_LW)) && (dest_d != 5'd0);
  assign rda_d  = rf_read(rs_d);
  assign rdb_d  = rf_read(rt_d);

  // ---------------- EX ----------------
  // Youngest producer wins: EX/MEM is checked before MEM/WB. A load sitting
  // in EX/MEM never matches a consumer in EX because load-use stalls first.
  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] base);
    if (ex_mem_v && ex_mem_wen && (ex_mem_dest == idx))      return ex_mem_alu;
    else if (mem_wb_v && mem_wb_wen && (mem_wb_dest == idx)) return mem_wb_val;
    else                                                     return base;
  endfunction

  logic [5:0]  op_e;
  logic [31:0] a_e, b_e, imm_e, alu_e;
  logic        taken;
  logic [9:0]  target;

  assign op_e   = id_ex_ir[31:26];
  assign imm_e  = {{16{id_ex_ir[15]}}, id_ex_ir[15:0]};
  assign a_e    = fwd(id_ex_ir[25:21], id_ex_a);
  assign b_e    = fwd(id_ex_ir[20:16], id_ex_b);
  assign taken  = id_ex_v && (((op_e == OP_BNEQZ) && (a_e != 32'd0)) ||
                              ((op_e == OP_BEQZ)  && (a_e == 32'd0)));
  assign target = id_ex_npc + imm_e[9:0];

  always_comb begin
    alu_e = 32'd0;
    case (op_e)
      OP_ADD:         alu_e = a_e + b_e;
      OP_SUB:         alu_e = a_e - b_e;
      OP_AND:         alu_e = a_e & b_e;
      OP_OR:          alu_e = a_e | b_e;
      OP_SLT:         alu_e = {31'd0, $signed(a_e) < $signed(b_e)};
      OP_MUL:         alu_e = a_e * b_e;
      OP_ADDI:        alu_e = a_e + imm_e;
      OP_SUBI:        alu_e = a_e - imm_e;
      OP_SLTI:        alu_e = {31'd0, $signed(a_e) < $signed(imm_e)};
      OP_LW, OP_SW:   alu_e = a_e + imm_e;
      default:        alu_e = 32'd0;
    endcase
  end

  // ---------------- MEM ----------------
  logic [31:0] mem_res;
  assign mem_res = ex_mem_lw ? MEM[ex_mem_alu[9:0]] : ex_mem_alu;

  // ---------------- hazard control ----------------
  logic load_use, halt_pend, fetch_adv;

  assign load_use = id_ex_v && (op_e == OP_LW) && id_ex_wen && if_id_v &&
                    ((uses_rs(op_d) && (rs_d == id_ex_dest)) ||
                     (uses_rt(op_d) && (rt_d == id_ex_dest)));

  // Any HLT from ID onward freezes fetch; once HALTED is set it stays frozen.
  assign halt_pend = HALTED ||
                     (if_id_v  && (op_d == OP_HLT)) ||
                     (id_ex_v  && (op_e == OP_HLT)) ||
                     (ex_mem_v && ex_mem_hlt) ||
                     (mem_wb_v && mem_wb_hlt);

  // A taken branch outranks both halt drain and stall: everything it
  // flushes is younger than the branch itself.
  assign fetch_adv = !taken && !halt_pend && !load_use;

  // Control state: asynchronously reset.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= 10'd0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      if_id_v      <= 1'b0;
      id_ex_v      <= 1'b0;
      ex_mem_v     <= 1'b0;
      mem_wb_v     <= 1'b0;
    end else begin
      TAKEN_BRANCH <= taken;
      if (mem_wb_v && mem_wb_hlt) HALTED <= 1'b1;

      if (taken) begin
        PC      <= target;
        if_id_v <= 1'b0;
      end else if (halt_pend) begin
        if_id_v <= 1'b0;
      end else if (!load_use) begin
        PC      <= PC + 10'd1;
        if_id_v <= 1'b1;
      end

      id_ex_v  <= if_id_v && !taken && !load_use;
      ex_mem_v <= id_ex_v;
      mem_wb_v <= ex_mem_v;
    end
  end

  // Payload registers: qualified by the valid bits above, so no reset.
  always_ff @(posedge clk1) begin
    if (fetch_adv) begin
      if_id_ir  <= MEM[PC];
      if_id_npc <= PC + 10'd1;
    end
    id_ex_ir    <= if_id_ir;
    id_ex_npc   <= if_id_npc;
    id_ex_a     <= rda_d;
    id_ex_b     <= rdb_d;
    id_ex_dest  <= dest_d;
    id_ex_wen   <= wen_d;
    ex_mem_alu  <= alu_e;
    ex_mem_b    <= b_e;
    ex_mem_dest <= id_ex_dest;
    ex_mem_wen  <= id_ex_wen;
    ex_mem_lw   <= (op_e == OP_LW);
    ex_mem_sw   <= (op_e == OP_SW);
    ex_mem_hlt  <= (op_e == OP_HLT);
    mem_wb_val  <= mem_res;
    mem_wb_dest <= ex_mem_dest;
    mem_wb_wen  <= ex_mem_wen;
    mem_wb_hlt  <= ex_mem_hlt;
  end

  // Architectural arrays: never reset, so preloaded contents persist.
  always @(posedge clk1) begin
    if (ex_mem_v && ex_mem_sw && !HALTED) MEM[ex_mem_alu[9:0]] <= ex_mem_b;
    if (wb_we) REG[mem_wb_dest] <= mem_wb_val;
  end

endmodule

// File: tb/tb_pipe_mips32.sv
// tb_pipe_mips32: directed programs for pipe_mips32 with hand-computed
// register, memory, cycle and branch-count expectations.
module tb_pipe_mips32;

  logic clk1 = 1'b0;
  logic rst_n;
  logic halted;

  int n_vec = 0;
  int n_bad = 0;
  int cyc;
  int taken_cnt = 0;
  int taken_base;
  logic [31:0] prog [$];

  pipe_mips32 dut (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .halted (halted)
  );

  // ---------------- clock ----------------
  always #5 clk1 = ~clk1;

  always @(negedge clk1) if (dut.TAKEN_BRANCH === 1'b1) taken_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Holds reset, wipes REG/MEM, copies prog into MEM[0..].
  task automatic load_prog();
    rst_n = 1'b0;
    @(negedge clk1);
    for (int i = 0; i < 1024; i++) dut.MEM[i] = 32'd0;
    for (int i = 0; i < 32; i++)   dut.REG[i] = 32'd0;
    foreach (prog[i]) dut.MEM[i] = prog[i];
  endtask

  // Releases reset on a falling edge, then counts falling edges until halted.
  task automatic release_and_run(input int budget, output int cycles);
    @(negedge clk1);
    rst_n = 1'b1;
    taken_base = taken_cnt;
    cycles = 0;
    while (halted !== 1'b1 && cycles < budget) begin
      @(negedge clk1);
      cycles++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    #1;
    chk("reset_pc",     {22'd0, dut.PC}, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_taken",  {31'd0, dut.TAKEN_BRANCH}, 32'd0);

    // Back-to-back dependencies, no stalls: HLT is 5th -> halted after edge 9.
    prog = '{32'h2801000A, 32'h28020014, 32'h00221800, 32'h00632000, 32'hFC000000};
    load_prog();
    release_and_run(100, cyc);
    chk("dep_r3",     dut.REG[3], 32'd30);
    chk("dep_r4",     dut.REG[4], 32'd60);
    chk("dep_cycles", cyc, 32'd9);
    repeat (3) @(negedge clk1);
    chk("dep_pc_frozen", {22'd0, dut.PC}, 32'd5);
    chk("dep_halted",    {31'd0, halted}, 32'd1);

    // Load-use: one stall cycle -> HLT (4th) halts after edge 9 instead of 8.
    prog = '{32'h20220000, 32'h2842002D, 32'h24220001, 32'hFC000000};
    load_prog();
    dut.MEM[120] = 32'd85;
    dut.REG[1]   = 32'd120;
    release_and_run(100, cyc);
    chk("lu_mem121", dut.MEM[121], 32'd130);
    chk("lu_r2",     dut.REG[2], 32'd130);
    chk("lu_cycles", cyc, 32'd9);
    chk("lu_mem120", dut.MEM[120], 32'd85);

    // R0 immutability and signed SLT.
    prog = '{32'h28000005, 32'h2C050001, 32'h10A03000, 32'hFC000000};
    load_prog();
    release_and_run(100, cyc);
    chk("r0_zero",    dut.REG[0], 32'd0);
    chk("slt_r5",     dut.REG[5], 32'hFFFFFFFF);
    chk("slt_r6",     dut.REG[6], 32'd1);
    chk("slt_cycles", cyc, 32'd8);

    // Taken branch flushes ADDI R7 and a HLT; execution resumes at 3.
    prog = '{32'h38000002, 32'h28070001, 32'hFC000000, 32'h28080009, 32'hFC000000};
    load_prog();
    dut.REG[7] = 32'h55;
    release_and_run(100, cyc);
    chk("br_r7_kept",   dut.REG[7], 32'h55);
    chk("br_r8_target", dut.REG[8], 32'd9);
    chk("br_halted",    {31'd0, halted}, 32'd1);
    chk("br_cycles",    cyc, 32'd9);
    chk("br_taken_cnt", taken_cnt - taken_base, 32'd1);

    // Factorial of 7: 46 issue slots before HLT (6 taken branches x 2 bubbles).
    prog = '{32'h280A00C8, 32'h28020001, 32'h0CE77800, 32'h21430000,
             32'h0CE77800, 32'h14431000, 32'h2C630001, 32'h0CE77800,
             32'h3460FFFC, 32'h2542FFFE, 32'hFC000000};
    load_prog();
    dut.MEM[200] = 32'd7;
    release_and_run(100, cyc);
    chk("fact_mem198", dut.MEM[198], 32'd5040);
    chk("fact_r3",     dut.REG[3], 32'd0);
    chk("fact_r2",     dut.REG[2], 32'd5040);
    chk("fact_halted", {31'd0, halted}, 32'd1);
    chk("fact_cycles", cyc, 32'd51);
    chk("fact_taken",  taken_cnt - taken_base, 32'd6);

    // Reset mid-loop, away from any clock edge, then rerun from MEM[0].
    load_prog();
    dut.MEM[200] = 32'd7;
    @(negedge clk1);
    rst_n = 1'b1;
    repeat (30) @(negedge clk1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pc",     {22'd0, dut.PC}, 32'd0);
    chk("midrst_halted", {31'd0, halted}, 32'd0);
    chk("midrst_mem198", dut.MEM[198], 32'd0);
    @(negedge clk1);
    release_and_run(100, cyc);
    chk("rerun_mem198", dut.MEM[198], 32'd5040);
    chk("rerun_r3",     dut.REG[3], 32'd0);
    chk("rerun_cycles", cyc, 32'd51);
    chk("rerun_taken",  taken_cnt - taken_base, 32'd6);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
